dac_sample_feeder: RTL and testbench
====================================

DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO depth (power of two, 4..64).
REQ-002 SHALL have parameter GUARD_CYCLES, default 4, idle clocks between dac_done rise and next dac_start.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  level; 1 = run sample timer and issue transfers.
REQ-006 SHALL have port period  input  32  sample period in clk cycles.
REQ-007 SHALL have ports wr_data (input, 16, sample), wr_valid (input, 1) and wr_ready (output, 1) as the FIFO write handshake.
REQ-008 SHALL have port fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-009 SHALL have ports underflow (output, 1, sticky) and tick_miss (output, 1, sticky), both cleared by clr_flags (input, 1).
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have ports dac_data (output, 16) and dac_start (output, 1) driving the downstream DAC SPI serializer.
REQ-012 SHALL have port dac_done  input  1  done level from the serializer.

Function
REQ-013 SHALL transfer a write when wr_valid and wr_ready are both high; wr_ready = (fifo_level < FIFO_DEPTH).
REQ-014 Simultaneous write and pop SHALL change fifo_level by net 0; an empty FIFO SHALL not bypass a same-cycle write to a pop.
REQ-015 Sample timer SHALL count 0..P-1, where P = max(period, 2); tick = enable and count == P-1; count SHALL hold 0 while enable is low.
REQ-016 FSM states SHALL be IDLE, WAIT_TICK, START, XFER and GUARD.
REQ-017 IDLE: SHALL go to WAIT_TICK when enable is 1.
REQ-018 WAIT_TICK: on tick with FIFO non-empty, SHALL pop the head into dac_data and go to START.
REQ-019 WAIT_TICK: on tick with FIFO empty, SHALL set underflow (see REQ-030/031); if enable is 0, SHALL go to IDLE.
REQ-020 START: SHALL drive dac_start high for exactly 1 cycle, then go to XFER.
REQ-021 XFER: SHALL wait for a 0->1 edge of dac_done (registered previous value), then go to GUARD.
REQ-022 GUARD: SHALL count GUARD_CYCLES clocks, then go to WAIT_TICK.
REQ-023 A tick occurring in START, XFER or GUARD SHALL set tick_miss and SHALL be dropped, not queued.
REQ-024 dac_data SHALL remain stable from START until the next pop.
REQ-025 enable falling mid-transfer SHALL let the current transfer complete through GUARD, then WAIT_TICK -> IDLE.
REQ-026 clr_flags coinciding with a flag-set event: set SHALL win.
REQ-027 Latency: dac_start SHALL rise 2 clocks after the tick cycle.

Reset
REQ-028 On rst SHALL give: state IDLE, FIFO flushed (fifo_level 0, wr_ready 1), timer 0, dac_start 0, dac_data 0x0000, underflow 0, tick_miss 0, busy 0, GUARD counter 0.
REQ-029 rst mid-transfer SHALL abort with no further dac_start; the first post-reset start SHALL occur no earlier than one full period after enable.

Configuration
REQ-030 With macro DAC_REPEAT_ON_EMPTY_EN defined, an empty-FIFO tick SHALL set underflow and re-issue the last dac_data (0x0000 after reset) through START/XFER/GUARD.
REQ-031 Without DAC_REPEAT_ON_EMPTY_EN, an empty-FIFO tick SHALL set underflow, issue no transfer, and stay in WAIT_TICK.

Verification
REQ-032 Bench SHALL cover: period=100, GUARD_CYCLES=4, write 0x1234, 0xABCD, enable=1 -> two dac_start pulses 100 clocks apart with dac_data 0x1234 then 0xABCD, fifo_level 2->0.
REQ-033 Bench SHALL cover: 16 writes with no enable, then a 17th with wr_valid -> wr_ready=0, fifo_level=16, 17th sample not stored.
REQ-034 Bench SHALL cover: enable with empty FIFO, period=50 -> underflow=1 at first tick; macro off: no dac_start; macro on: dac_start with dac_data 0x0000.
REQ-035 Bench SHALL cover: period=10 with serializer frame longer than 10 clocks -> tick_miss=1, no dac_start while busy; clr_flags clears it.
REQ-036 Bench SHALL cover: rst asserted in XFER -> next cycle dac_start=0, fifo_level=0, busy=0; no dac_start until >=period clocks after re-enable.
REQ-037 Bench SHALL cover: enable dropped in XFER -> dac_done edge accepted, GUARD completes, returns to IDLE, busy=0.

Source files
------------

// File: rtl/dac_sample_feeder_if.sv
// Write-side handshake bundle for dac_sample_feeder: a producer offers samples, the feeder answers ready.
interface dac_sample_feeder_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/dac_sample_feeder.sv
// Paced DAC sample feeder: buffers samples in a FIFO and hands one to the SPI serializer per timer tick.
// Optional macro DAC_REPEAT_ON_EMPTY_EN: an empty-FIFO tick re-sends the last sample instead of skipping.
module dac_sample_feeder #(
  parameter int FIFO_DEPTH   = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [31:0]                 period,
  dac_sample_feeder_if.slave          wr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        clr_flags,
  output logic                        underflow,
  output logic                        tick_miss,
  output logic                        busy,
  output logic [15:0]                 dac_data,
  output logic                        dac_start,
  input  logic                        dac_done
);
  localparam int DATA_W = 16;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int GW     = $clog2(GUARD_CYCLES + 2);
  localparam logic [GW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;
  localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_XFER,
    S_GUARD
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [31:0]         count_q, count_d;
  logic [GW-1:0]       guard_cnt_q, guard_cnt_d;
  logic [DATA_W-1:0]   dac_data_q, dac_data_d;
  logic                dac_start_q, dac_start_d;
  logic                underflow_q, underflow_d;
  logic                tick_miss_q, tick_miss_d;
  logic                done_prev_q, done_prev_d;

  logic [31:0]         period_m1;
  logic                tick;
  logic                fifo_empty;
  logic                wr_ready_c;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   head;
  logic                done_rise;
  logic                underflow_set;
  logic                tick_miss_set;

  // Sample timer: a period below 2 is treated as 2 so a tick never fires on consecutive clocks.
  always_comb begin
    period_m1 = (period < 32'd2) ? 32'd1 : (period - 32'd1);
    tick      = enable && (count_q >= period_m1);
    count_d   = (!enable || (count_q >= period_m1)) ? '0 : (count_q + 32'd1);
  end

  always_comb begin
    fifo_empty  = (level_q == '0);
    wr_ready_c  = (level_q < DEPTH_L);
    push        = wr.wr_valid && wr_ready_c;
    head        = mem_q[rd_ptr_q];
    done_rise   = dac_done && !done_prev_q;
    done_prev_d = dac_done;
  end

  // Pop only ever reads stored entries, so an empty FIFO never forwards a same-cycle write.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr.wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    dac_data_d    = dac_data_q;
    guard_cnt_d   = guard_cnt_q;
    underflow_set = 1'b0;
    tick_miss_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        guard_cnt_d = '0;
        if (enable) begin
          state_d = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            dac_data_d = head;
            state_d    = S_START;
          end else begin
            underflow_set = 1'b1;
`ifdef DAC_REPEAT_ON_EMPTY_EN
            state_d = S_START;
`else
            state_d = S_WAIT_TICK;
`endif
          end
        end
      end
      S_START: begin
        tick_miss_set = tick;
        state_d       = S_XFER;
      end
      S_XFER: begin
        tick_miss_set = tick;
        if (done_rise) begin
          guard_cnt_d = '0;
          state_d     = (GUARD_CYCLES > 0) ? S_GUARD : S_WAIT_TICK;
        end
      end
      S_GUARD: begin
        tick_miss_set = tick;
        if (guard_cnt_q == GUARD_LAST) begin
          guard_cnt_d = '0;
          state_d     = S_WAIT_TICK;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Flags are sticky; a set in the same cycle as clr_flags takes priority.
  always_comb begin
    dac_start_d = (state_q == S_START);
    underflow_d = underflow_set ? 1'b1 : (clr_flags ? 1'b0 : underflow_q);
    tick_miss_d = tick_miss_set ? 1'b1 : (clr_flags ? 1'b0 : tick_miss_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      count_q     <= '0;
      guard_cnt_q <= '0;
      dac_data_q  <= '0;
      dac_start_q <= 1'b0;
      underflow_q <= 1'b0;
      tick_miss_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      count_q     <= count_d;
      guard_cnt_q <= guard_cnt_d;
      dac_data_q  <= dac_data_d;
      dac_start_q <= dac_start_d;
      underflow_q <= underflow_d;
      tick_miss_q <= tick_miss_d;
      done_prev_q <= done_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wr.wr_ready  = wr_ready_c;
  assign fifo_level   = level_q;
  assign busy         = (state_q != S_IDLE);
  assign dac_data     = dac_data_q;
  assign dac_start    = dac_start_q;
  assign underflow    = underflow_q;
  assign tick_miss    = tick_miss_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Self-checking bench for dac_sample_feeder with a behavioural serializer and a tick-level schedule model.
module tb_dac_sample_feeder;
  localparam int DEPTH = 16;
  localparam int GUARD = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        enable    = 1'b0;
  logic        clr_flags = 1'b0;
  logic        dac_done  = 1'b0;
  logic [31:0] period    = 32'd100;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        underflow, tick_miss, busy, dac_start;
  logic [15:0] dac_data;

  dac_sample_feeder_if #(.DATA_W(16)) wr_if ();

  dac_sample_feeder #(.FIFO_DEPTH(DEPTH), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .wr(wr_if),
    .fifo_level(fifo_level), .clr_flags(clr_flags), .underflow(underflow),
    .tick_miss(tick_miss), .busy(busy), .dac_data(dac_data),
    .dac_start(dac_start), .dac_done(dac_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_len = 10;
  int ser_cnt = 0;
  int          start_cyc_q[$];
  logic [15:0] start_dat_q[$];

  logic [15:0] mdl_in_q[$];
  int          exp_cyc_q[$];
  logic [15:0] exp_dat_q[$];
  bit          exp_uf, exp_miss;
  int          exp_left;

  // Edge counter, start logger and serializer: done drops on start and rises frame_len clocks later.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (dac_start === 1'b1) begin
      start_cyc_q.push_back(cyc);
      start_dat_q.push_back(dac_data);
      ser_cnt  = frame_len;
      dac_done = 1'b0;
    end else if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) dac_done = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  // Schedule model: ticks every P clocks from enable; a tick is served only if the previous
  // frame plus guard has finished, otherwise it is counted as a miss.
  task automatic run_model(input int n, input int p, input int f, input int horizon, input logic [15:0] last_in);
    int          ready;
    int          pe;
    int          s;
    logic [15:0] last;
    logic [15:0] src[$];
    src = mdl_in_q;
    exp_cyc_q.delete();
    exp_dat_q.delete();
    exp_uf   = 1'b0;
    exp_miss = 1'b0;
    pe    = (p < 2) ? 2 : p;
    ready = n;
    last  = last_in;
    for (int t = n + pe - 1; t < horizon; t += pe) begin
      if (t < ready) begin
        exp_miss = 1'b1;
      end else if (src.size() > 0) begin
        last  = src.pop_front();
        s     = t + 1;
        exp_cyc_q.push_back(s);
        exp_dat_q.push_back(last);
        ready = s + f + GUARD + 2;
      end else begin
        exp_uf = 1'b1;
`ifdef DAC_REPEAT_ON_EMPTY_EN
        s = t + 1;
        exp_cyc_q.push_back(s);
        exp_dat_q.push_back(last);
        ready = s + f + GUARD + 2;
`endif
      end
    end
    exp_left = src.size();
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; clr_flags = 1'b0; wr_if.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_cyc_q.delete();
    start_dat_q.delete();
    mdl_in_q.delete();
  endtask

  task automatic push_sample(input logic [15:0] d);
    @(negedge clk);
    wr_if.wr_data  = d;
    wr_if.wr_valid = 1'b1;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic start_run(input int p, input int f, output int n);
    @(negedge clk);
    period    = 32'(p);
    frame_len = f;
    enable    = 1'b1;
    n         = cyc + 1;
  endtask

  task automatic test_reset();
    wr_if.wr_data = 16'h0; wr_if.wr_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_if.wr_ready); end
    checks++; if (dac_start !== 1'b0) begin errors++; $display("FAIL reset_dac_start got %b want 0", dac_start); end
    checks++; if (dac_data !== 16'h0000) begin errors++; $display("FAIL reset_dac_data got %h want 0000", dac_data); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
    checks++; if (tick_miss !== 1'b0) begin errors++; $display("FAIL reset_tick_miss got %b want 0", tick_miss); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_two_samples();
    int n;
    do_reset();
    push_sample(16'h1234);
    push_sample(16'hABCD);
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL two_level_before got %0d want 2", fifo_level); end
    start_run(100, $urandom_range(5, 40), n);
    wait_cyc(n + 100);
    checks++; if (start_cyc_q.size() != 1 || start_cyc_q[0] != n + 100)
      begin errors++; $display("FAIL two_first_start got n=%0d at %0d want at %0d", start_cyc_q.size(), (start_cyc_q.size() > 0) ? start_cyc_q[0] : -1, n + 100); end
    checks++; if (start_dat_q.size() < 1 || start_dat_q[0] !== 16'h1234)
      begin errors++; $display("FAIL two_first_data got %h want 1234", (start_dat_q.size() > 0) ? start_dat_q[0] : 16'hxxxx); end
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL two_level_mid got %0d want 1", fifo_level); end
    wait_cyc(n + 205);
    checks++; if (start_cyc_q.size() != 2 || start_cyc_q[1] - start_cyc_q[0] != 100)
      begin errors++; $display("FAIL two_spacing got count %0d want 2 pulses 100 apart", start_cyc_q.size()); end
    checks++; if (start_dat_q.size() < 2 || start_dat_q[1] !== 16'hABCD)
      begin errors++; $display("FAIL two_second_data got %h want abcd", (start_dat_q.size() > 1) ? start_dat_q[1] : 16'hxxxx); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL two_level_after got %0d want 0", fifo_level); end
    enable = 1'b0;
  endtask

  task automatic test_fifo_full();
    int n;
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = 16'($urandom);
      push_sample(d);
      mdl_in_q.push_back(d);
    end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", fifo_level); end
    @(negedge clk);
    wr_if.wr_data = ~mdl_in_q[0]; wr_if.wr_valid = 1'b1;
    checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b want 0", wr_if.wr_ready); end
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level_17th got %0d want 16", fifo_level); end
    start_run(20, 5, n);
    run_model(n, 20, 5, n + 330, 16'h0000);
    wait_cyc(n + 330);
    checks++; if (start_cyc_q.size() != exp_cyc_q.size())
      begin errors++; $display("FAIL full_count got %0d want %0d", start_cyc_q.size(), exp_cyc_q.size()); end
    for (int i = 0; i < exp_cyc_q.size() && i < start_cyc_q.size(); i++) begin
      checks++; if (start_cyc_q[i] != exp_cyc_q[i] || start_dat_q[i] !== exp_dat_q[i])
        begin errors++; $display("FAIL full_xfer%0d got %h@%0d want %h@%0d", i, start_dat_q[i], start_cyc_q[i], exp_dat_q[i], exp_cyc_q[i]); end
    end
    checks++; if (fifo_level !== 5'(exp_left)) begin errors++; $display("FAIL full_level_end got %0d want %0d", fifo_level, exp_left); end
    enable = 1'b0;
  endtask

  task automatic test_underflow();
    int n;
    do_reset();
    start_run(50, 10, n);
    wait_cyc(n + 48);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before_tick got %b want 0", underflow); end
    wait_cyc(n + 49);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_at_tick got %b want 1", underflow); end
    wait_cyc(n + 60);
`ifdef DAC_REPEAT_ON_EMPTY_EN
    checks++; if (start_cyc_q.size() != 1 || start_cyc_q[0] != n + 50 || start_dat_q[0] !== 16'h0000)
      begin errors++; $display("FAIL uf_repeat got count %0d want one start of 0000 at %0d", start_cyc_q.size(), n + 50); end
`else
    checks++; if (start_cyc_q.size() != 0)
      begin errors++; $display("FAIL uf_no_start got %0d starts want 0", start_cyc_q.size()); end
`endif
    enable = 1'b0;
  endtask

  task automatic test_tick_miss();
    int n;
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      push_sample(d);
      mdl_in_q.push_back(d);
    end
    start_run(10, 25, n);
    run_model(n, 10, 25, n + 135, 16'h0000);
    wait_cyc(n + 135);
    checks++; if (start_cyc_q.size() != exp_cyc_q.size())
      begin errors++; $display("FAIL miss_count got %0d want %0d", start_cyc_q.size(), exp_cyc_q.size()); end
    for (int i = 0; i < exp_cyc_q.size() && i < start_cyc_q.size(); i++) begin
      checks++; if (start_cyc_q[i] != exp_cyc_q[i] || start_dat_q[i] !== exp_dat_q[i])
        begin errors++; $display("FAIL miss_xfer%0d got %h@%0d want %h@%0d", i, start_dat_q[i], start_cyc_q[i], exp_dat_q[i], exp_cyc_q[i]); end
    end
    checks++; if (tick_miss !== 1'b1) begin errors++; $display("FAIL miss_flag got %b want 1", tick_miss); end
    checks++; if (underflow !== exp_uf) begin errors++; $display("FAIL miss_uf got %b want %b", underflow, exp_uf); end
    enable = 1'b0;
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL miss_idle_wait got busy=%b want 0", busy); end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++; if (tick_miss !== 1'b0 || underflow !== 1'b0)
      begin errors++; $display("FAIL miss_clear got miss=%b uf=%b want 0 0", tick_miss, underflow); end
  endtask

  task automatic test_reset_mid();
    int n, n2, p;
    logic [15:0] c;
    do_reset();
    push_sample(16'($urandom));
    push_sample(16'($urandom));
    p = $urandom_range(20, 60);
    start_run(p, 30, n);
    wait_cyc(n + p + 3);
    checks++; if (start_cyc_q.size() != 1 || start_cyc_q[0] != n + p)
      begin errors++; $display("FAIL rstmid_first got count %0d want one start at %0d", start_cyc_q.size(), n + p); end
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    checks++; if (dac_start !== 1'b0 || fifo_level !== 5'd0 || busy !== 1'b0 || wr_if.wr_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_state got start=%b level=%0d busy=%b ready=%b want 0 0 0 1", dac_start, fifo_level, busy, wr_if.wr_ready); end
    rst = 1'b0;
    start_cyc_q.delete();
    start_dat_q.delete();
    c = 16'($urandom);
    push_sample(c);
    start_run(p, 30, n2);
    wait_cyc(n2 + p);
    checks++; if (start_cyc_q.size() != 1 || start_cyc_q[0] != n2 + p || start_dat_q[0] !== c)
      begin errors++; $display("FAIL rstmid_restart got count %0d want one start of %h at %0d", start_cyc_q.size(), c, n2 + p); end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int n, s;
    do_reset();
    push_sample(16'($urandom));
    start_run(30, 15, n);
    wait_cyc(n + 30);
    checks++; if (start_cyc_q.size() != 1) begin errors++; $display("FAIL drop_start got %0d starts want 1", start_cyc_q.size()); end
    s = n + 30;
    enable = 1'b0;
    wait_cyc(s + 15 + GUARD + 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_guard got %b want 1", busy); end
    wait_cyc(s + 15 + GUARD + 2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got %b want 0", busy); end
    checks++; if (start_cyc_q.size() != 1 || fifo_level !== 5'd0)
      begin errors++; $display("FAIL drop_final got starts=%0d level=%0d want 1 0", start_cyc_q.size(), fifo_level); end
  endtask

  task automatic test_random_stream();
    int n, k, p, f, horizon;
    logic [15:0] d;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      k = $urandom_range(2, 6);
      for (int i = 0; i < k; i++) begin
        d = 16'($urandom);
        push_sample(d);
        mdl_in_q.push_back(d);
      end
      p = $urandom_range(15, 40);
      f = $urandom_range(3, 20);
      start_run(p, f, n);
      horizon = n + (k + 1) * p + 3;
      run_model(n, p, f, horizon, 16'h0000);
      wait_cyc(horizon);
      checks++; if (start_cyc_q.size() != exp_cyc_q.size())
        begin errors++; $display("FAIL rand%0d_count got %0d want %0d (p=%0d f=%0d)", it, start_cyc_q.size(), exp_cyc_q.size(), p, f); end
      for (int i = 0; i < exp_cyc_q.size() && i < start_cyc_q.size(); i++) begin
        checks++; if (start_cyc_q[i] != exp_cyc_q[i] || start_dat_q[i] !== exp_dat_q[i])
          begin errors++; $display("FAIL rand%0d_xfer%0d got %h@%0d want %h@%0d", it, i, start_dat_q[i], start_cyc_q[i], exp_dat_q[i], exp_cyc_q[i]); end
      end
      checks++; if (tick_miss !== exp_miss || underflow !== exp_uf)
        begin errors++; $display("FAIL rand%0d_flags got miss=%b uf=%b want %b %b", it, tick_miss, underflow, exp_miss, exp_uf); end
      checks++; if (fifo_level !== 5'(exp_left))
        begin errors++; $display("FAIL rand%0d_level got %0d want %0d", it, fifo_level, exp_left); end
      enable = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_two_samples();
    test_fifo_full();
    test_underflow();
    test_tick_miss();
    test_reset_mid();
    test_enable_drop();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
